craps_game_ctrl: RTL and testbench

- Game controller for the two-dice craps lab.
- Converts a player "roll" push-button into two dice values and tracks the come-out and point phases.
- Drives dice1/dice2/point/point_active directly into the 7-segment display stage; win/lose go to LEDs.
- Single clock domain; button synchronised internally.

---
 rtl/craps_pkg.sv | 27 ++
 rtl/craps_game_ctrl_dice_gen.sv | 56 +++++
 rtl/craps_game_ctrl.sv | 128 ++++++++++++
 tb/tb_craps_game_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/craps_pkg.sv
// Shared types and constants for the craps game controller.
// CRAPS_LFSR_DICE_EN selects the LFSR dice engine in dice_gen.
package craps_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] DIE_MAX    = 4'd6;
    localparam logic [3:0] NAT_WIN_7  = 4'd7;
    localparam logic [3:0] NAT_WIN_11 = 4'd11;
    localparam logic [3:0] CRAPS_2    = 4'd2;
    localparam logic [3:0] CRAPS_3    = 4'd3;
    localparam logic [3:0] CRAPS_12   = 4'd12;

    // Taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] dice_sum(input logic [3:0] a, input logic [3:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/craps_game_ctrl_dice_gen.sv
// Dice engine: 36-step odometer by default, or LFSR sampling when
// CRAPS_LFSR_DICE_EN is defined.
module dice_gen
    import craps_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       latch,
    output logic [3:0] dice1,
    output logic [3:0] dice2
);

`ifdef CRAPS_LFSR_DICE_EN
    logic [15:0] lfsr;
    logic [5:0]  idx;
    logic        unused_advance;

    assign unused_advance = advance;
    assign idx = 6'(lfsr % 16'd36);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr  <= LFSR_SEED;
            dice1 <= 4'd1;
            dice2 <= 4'd1;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            if (latch) begin
                dice1 <= 4'(idx % 6'd6) + 4'd1;
                dice2 <= 4'(idx / 6'd6) + 4'd1;
            end
        end
    end
`else
    logic unused_latch;

    assign unused_latch = latch;

    // Dice pair is held directly as the odometer digits; 6,6 wraps to 1,1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dice1 <= 4'd1;
            dice2 <= 4'd1;
        end else if (advance) begin
            if (dice1 == DIE_MAX) begin
                dice1 <= 4'd1;
                dice2 <= (dice2 == DIE_MAX) ? 4'd1 : dice2 + 4'd1;
            end else begin
                dice1 <= dice1 + 4'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/craps_game_ctrl.sv
// Craps game controller: button sync, roll FSM and come-out/point rules.
// Optional macro CRAPS_LFSR_DICE_EN switches the dice engine to an LFSR.
//
// state   | meaning
// IDLE    | waiting for a roll press (come-out or point phase)
// ROLLING | button held, dice advancing
// EVAL    | one cycle: score the dice against the rules
// DONE    | game over, win/lose held until the next press
module craps_game_ctrl
    import craps_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll,
    output logic [3:0] dice1,
    output logic [3:0] dice2,
    output logic [3:0] point,
    output logic       point_active,
    output logic       win,
    output logic       lose
);

    logic [SYNC_STAGES-1:0] sync;
    logic       roll_s, roll_d, rise, fall;
    state_t     state, state_next;
    logic [3:0] point_next, sum;
    logic       point_active_next, win_next, lose_next;
    logic       advance, latch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            roll_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], roll};
            roll_d <= roll_s;
        end
    end

    assign roll_s  = sync[SYNC_STAGES-1];
    assign rise    = roll_s & ~roll_d;
    assign fall    = ~roll_s & roll_d;
    // The falling-edge cycle does not count as a dice step.
    assign advance = (state == ROLLING) && !fall;
    assign latch   = (state == ROLLING) && fall;
    assign sum     = dice_sum(dice1, dice2);

    dice_gen u_dice_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance),
        .latch   (latch),
        .dice1   (dice1),
        .dice2   (dice2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            point        <= 4'd0;
            point_active <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            state        <= state_next;
            point        <= point_next;
            point_active <= point_active_next;
            win          <= win_next;
            lose         <= lose_next;
        end
    end

    always_comb begin
        state_next        = state;
        point_next        = point;
        point_active_next = point_active;
        win_next          = win;
        lose_next         = lose;
        case (state)
            IDLE: begin
                if (rise) state_next = ROLLING;
            end
            ROLLING: begin
                if (fall) state_next = EVAL;
            end
            EVAL: begin
                if (!point_active) begin
                    if (sum == NAT_WIN_7 || sum == NAT_WIN_11) begin
                        win_next   = 1'b1;
                        state_next = DONE;
                    end else if (sum == CRAPS_2 || sum == CRAPS_3 || sum == CRAPS_12) begin
                        lose_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        point_next        = sum;
                        point_active_next = 1'b1;
                        state_next        = IDLE;
                    end
                end else if (sum == point) begin
                    win_next          = 1'b1;
                    point_next        = 4'd0;
                    point_active_next = 1'b0;
                    state_next        = DONE;
                end else if (sum == NAT_WIN_7) begin
                    lose_next         = 1'b1;
                    point_next        = 4'd0;
                    point_active_next = 1'b0;
                    state_next        = DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                if (rise) begin
                    state_next        = ROLLING;
                    win_next          = 1'b0;
                    lose_next         = 1'b0;
                    point_next        = 4'd0;
                    point_active_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_craps_game_ctrl.sv
// Self-checking bench for craps_game_ctrl (default odometer dice build).
module tb_craps_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       roll = 1'b0;
    logic [3:0] dice1, dice2, point;
    logic       point_active, win, lose;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: dice as a position 0..35 around the pair table,
    // game as plain rule evaluation on the resulting sum.
    int  m_pos;
    int  m_d1, m_d2, m_point;
    bit  m_pa, m_win, m_lose;
    bit  check_en = 1'b0;

    craps_game_ctrl #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .roll         (roll),
        .dice1        (dice1),
        .dice2        (dice2),
        .point        (point),
        .point_active (point_active),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pos = 0; m_d1 = 1; m_d2 = 1;
        m_point = 0; m_pa = 0; m_win = 0; m_lose = 0;
    endfunction

    function automatic void model_roll(input int steps);
        int s;
        m_pos = (m_pos + steps) % 36;
        m_d1  = m_pos % 6 + 1;
        m_d2  = m_pos / 6 + 1;
        s     = m_d1 + m_d2;
        m_win = 0; m_lose = 0;
        if (!m_pa) begin
            if (s == 7 || s == 11)                m_win = 1;
            else if (s == 2 || s == 3 || s == 12) m_lose = 1;
            else begin m_point = s; m_pa = 1; end
        end else if (s == m_point) begin
            m_win = 1; m_pa = 0; m_point = 0;
        end else if (s == 7) begin
            m_lose = 1; m_pa = 0; m_point = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (check_en && rst_n) begin
            check("dice1", dice1, m_d1);
            check("dice2", dice2, m_d2);
            check("point", point, m_point);
            check("point_active", point_active, m_pa);
            check("win", win, m_win);
            check("lose", lose, m_lose);
            check("win_lose_excl", win & lose, 0);
        end
    end

    // Hold the button for 'hold' clocks (hold-1 dice steps), then let it settle.
    task automatic do_roll(input int hold);
        int old_d1, old_d2;
        old_d1 = m_d1; old_d2 = m_d2;
        check_en = 1'b0;
        @(posedge clk); #1;
        roll = 1'b1;
        for (int i = 1; i <= hold + 6; i++) begin
            @(posedge clk); #1;
            if (i == hold) roll = 1'b0;
            if (i == 3) begin
                check("clear_on_press_win", win, 0);
                check("clear_on_press_lose", lose, 0);
                check("hold_dice1_at_start", dice1, old_d1);
                check("hold_dice2_at_start", dice2, old_d2);
            end
        end
        model_roll(hold - 1);
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        roll = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_dice1", dice1, 1);
        check("rst_dice2", dice2, 1);
        check("rst_point", point, 0);
        check("rst_point_active", point_active, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();

        // 5 steps -> (6,1) sum 7, natural win
        do_roll(6);
        check("t1_dice1", dice1, 6);
        check("t1_dice2", dice2, 1);
        check("t1_win", win, 1);
        check("t1_point_active", point_active, 0);

        // continue from held dice: 1 step -> (1,2) sum 3, lose
        do_roll(2);
        check("t5_dice1", dice1, 1);
        check("t5_dice2", dice2, 2);
        check("t5_lose", lose, 1);
        check("t5_win", win, 0);

        do_reset();
        do_roll(2);
        check("t2_dice1", dice1, 2);
        check("t2_dice2", dice2, 1);
        check("t2_lose", lose, 1);

        do_reset();
        do_roll(18);
        check("t3_dice1", dice1, 6);
        check("t3_dice2", dice2, 3);
        check("t3_point", point, 9);
        check("t3_point_active", point_active, 1);
        check("t3_win", win, 0);
        check("t3_lose", lose, 0);
        do_roll(37);
        check("t3b_win", win, 1);
        check("t3b_point", point, 0);
        check("t3b_point_active", point_active, 0);

        do_reset();
        do_roll(18);
        do_roll(13);
        check("t4_dice1", dice1, 6);
        check("t4_dice2", dice2, 5);
        check("t4_point", point, 9);
        check("t4_win", win, 0);
        do_roll(2);
        check("t4b_dice1", dice1, 1);
        check("t4b_dice2", dice2, 6);
        check("t4b_lose", lose, 1);
        check("t4b_point", point, 0);

        // reset in the middle of a roll
        check_en = 1'b0;
        @(posedge clk); #1;
        roll = 1'b1;
        repeat (8) @(posedge clk);
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        check("t6_win", win, 0);
        check("t6_lose", lose, 0);
        check("t6_dice1", dice1, 1);

        for (int r = 0; r < 60; r++) begin
            do_roll(int'($urandom_range(2, 40)));
        end

        check_en = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
